// File: rtl/wb_trace_writer.sv
// Dual-issue writeback trace recorder: serializes accepted register writes
// (slot 0 before slot 1) into an ordered record FIFO with a valid/ready output.
module wb_trace_writer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] END_PC    = 32'hbfc00100,
    parameter int          DROP_ZERO = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        open_trace,
    input  logic        wb0_en,
    input  logic [4:0]  wb0_rd,
    input  logic [31:0] wb0_wdata,
    input  logic [31:0] wb0_pc,
    input  logic        wb1_en,
    input  logic [4:0]  wb1_rd,
    input  logic [31:0] wb1_wdata,
    input  logic [31:0] wb1_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_flag,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic [31:0] out_wdata,
    output logic        stall_req,
    output logic        overflow,
    output logic        done,
    output logic [31:0] rec_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];
    logic [4:0]    rd_mem_q    [DEPTH];
    logic [4:0]    rd_mem_d    [DEPTH];
    logic [31:0]   wdata_mem_q [DEPTH];
    logic [31:0]   wdata_mem_d [DEPTH];
    logic          flag_mem_q  [DEPTH];
    logic          flag_mem_d  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic [31:0]   rec_count_q, rec_count_d;

    logic          cand0, cand1;
    logic          push_a, push_b;
    logic          pop;
    logic [1:0]    n_cand, n_push;
    logic [CW-1:0] free_space;
    logic [31:0]   a_pc, a_wdata;
    logic [4:0]    a_rd;

    // Entry "a" is the first record written this cycle (slot 0 if it is a
    // candidate, otherwise slot 1); entry "b" is only ever slot 1 behind slot 0.
    // Credit comes from the start-of-cycle count, so a same-cycle pop never helps.
    always_comb begin
        cand0      = wb0_en && !done_q && ((DROP_ZERO == 0) || (wb0_rd != 5'd0));
        cand1      = wb1_en && !done_q && ((DROP_ZERO == 0) || (wb1_rd != 5'd0));
        free_space = DEPTH_C - count_q;
        push_a     = (cand0 || cand1) && (free_space != '0);
        push_b     = cand0 && cand1 && (free_space >= CW'(2));
        pop        = (count_q != '0) && out_ready;
        n_cand     = {1'b0, cand0} + {1'b0, cand1};
        n_push     = {1'b0, push_a} + {1'b0, push_b};
        a_pc       = cand0 ? wb0_pc    : wb1_pc;
        a_rd       = cand0 ? wb0_rd    : wb1_rd;
        a_wdata    = cand0 ? wb0_wdata : wb1_wdata;
    end

    always_comb begin
        pc_mem_d    = pc_mem_q;
        rd_mem_d    = rd_mem_q;
        wdata_mem_d = wdata_mem_q;
        flag_mem_d  = flag_mem_q;
        if (push_a) begin
            pc_mem_d[wr_ptr_q]    = a_pc;
            rd_mem_d[wr_ptr_q]    = a_rd;
            wdata_mem_d[wr_ptr_q] = a_wdata;
            flag_mem_d[wr_ptr_q]  = open_trace;
        end
        if (push_b) begin
            pc_mem_d[wr_ptr_q + AW'(1)]    = wb1_pc;
            rd_mem_d[wr_ptr_q + AW'(1)]    = wb1_rd;
            wdata_mem_d[wr_ptr_q + AW'(1)] = wb1_wdata;
            flag_mem_d[wr_ptr_q + AW'(1)]  = open_trace;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(n_push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(n_push) - CW'(pop);
        overflow_d  = overflow_q || (n_cand != n_push);
        done_d      = done_q || (push_a && (a_pc == END_PC))
                             || (push_b && (wb1_pc == END_PC));
        rec_count_d = rec_count_q + 32'(n_push);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                rd_mem_q[i]    <= '0;
                wdata_mem_q[i] <= '0;
                flag_mem_q[i]  <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            rec_count_q <= '0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            rd_mem_q    <= rd_mem_d;
            wdata_mem_q <= wdata_mem_d;
            flag_mem_q  <= flag_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            rec_count_q <= rec_count_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_flag  = flag_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_rd    = rd_mem_q[rd_ptr_q];
    assign out_wdata = wdata_mem_q[rd_ptr_q];
    assign stall_req = (free_space < CW'(2));
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign rec_count = rec_count_q;

endmodule
